// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into one-shot press events, offered one at a time
// by a round-robin arbiter over valid/ready. Presses of an already-pending button are counted as drops.
module button_event_arbiter #(
    parameter int N_BUTTONS = 4,
    localparam int ID_W = $clog2(N_BUTTONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttons_pressed,
    input  logic                 event_ready,
    output logic                 event_valid,
    output logic [ID_W-1:0]      event_id,
    output logic [N_BUTTONS-1:0] pending,
    output logic [7:0]           drop_count
);

    typedef enum logic {
        S_IDLE,
        S_OFFER
    } state_t;

    state_t                 state_q, state_d;
    logic [N_BUTTONS-1:0]   prev_q, prev_d;
    logic [N_BUTTONS-1:0]   pending_q, pending_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic                   event_valid_q, event_valid_d;
    logic [ID_W-1:0]        event_id_q, event_id_d;
    logic [7:0]             drop_count_q, drop_count_d;

    logic [N_BUTTONS-1:0]   rise;
    logic [N_BUTTONS-1:0]   clear;
    logic [N_BUTTONS-1:0]   drop_vec;
    logic                   handshake;
    logic [5:0]             drop_num;
    logic [9:0]             drop_sum;
    logic                   rr_found;
    logic [ID_W-1:0]        rr_id;
    logic [6:0]             rr_best;
    logic [6:0]             rr_dist;
    logic [6:0]             ptr_ext;
    logic [ID_W-1:0]        ptr_next;

    always_comb begin
        prev_d    = buttons_pressed;
        rise      = buttons_pressed & ~prev_q;
        handshake = (state_q == S_OFFER) && event_ready;
        clear     = handshake ? ({{(N_BUTTONS-1){1'b0}}, 1'b1} << event_id_q) : '0;
        // A rise on the clear cycle re-arms the bit, so the new press survives.
        pending_d = rise | (pending_q & ~clear);
        drop_vec  = rise & pending_q & ~clear;
    end

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            drop_num = drop_num + 6'(drop_vec[i]);
        end
        drop_sum     = 10'(drop_count_q) + 10'(drop_num);
        drop_count_d = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
    end

    // Round-robin pick: the set bit with the smallest circular distance from ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = '0;
        rr_best  = '0;
        rr_dist  = '0;
        ptr_ext  = 7'(ptr_q);
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (7'(i) >= ptr_ext) begin
                rr_dist = 7'(i) - ptr_ext;
            end else begin
                rr_dist = 7'(i) + 7'(N_BUTTONS) - ptr_ext;
            end
            if (pending_q[i] && (!rr_found || rr_dist < rr_best)) begin
                rr_found = 1'b1;
                rr_best  = rr_dist;
                rr_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        ptr_next      = (event_id_q == ID_W'(N_BUTTONS - 1)) ? '0 : event_id_q + ID_W'(1);
        state_d       = state_q;
        event_valid_d = event_valid_q;
        event_id_d    = event_id_q;
        ptr_d         = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    state_d       = S_OFFER;
                    event_valid_d = 1'b1;
                    event_id_d    = rr_id;
                end
            end
            S_OFFER: begin
                if (handshake) begin
                    state_d       = S_IDLE;
                    event_valid_d = 1'b0;
                    ptr_d         = ptr_next;
                end
            end
            default: begin
                state_d       = S_IDLE;
                event_valid_d = 1'b0;
            end
        endcase
    end

    // Reset samples the live buttons so one held through reset raises no event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            prev_q        <= buttons_pressed;
            pending_q     <= '0;
            ptr_q         <= '0;
            event_valid_q <= 1'b0;
            event_id_q    <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            pending_q     <= pending_d;
            ptr_q         <= ptr_d;
            event_valid_q <= event_valid_d;
            event_id_q    <= event_id_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign event_valid = event_valid_q;
    assign event_id    = event_id_q;
    assign pending     = pending_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Randomized and directed bench for button_event_arbiter; a behavioural model predicts
// accepted events into a queue that a negedge monitor drains and compares.
module tb_button_event_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] buttons = '0;
    logic         event_ready = 1'b0;
    logic         event_valid;
    logic [1:0]   event_id;
    logic [N-1:0] pending;
    logic [7:0]   drop_count;

    int compared = 0;
    int mismatched = 0;

    bit m_prev[N];
    bit m_pend[N];
    int m_ptr;
    int m_id;
    int m_drops;
    bit m_off;
    bit m_known = 1'b0;
    int exp_q[$];

    button_event_arbiter #(.N_BUTTONS(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .buttons_pressed(buttons),
        .event_ready    (event_ready),
        .event_valid    (event_valid),
        .event_id       (event_id),
        .pending        (pending),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Predicts the state after the coming rising edge from the current state and inputs.
    task automatic model_step(input logic [N-1:0] b, input bit r, input bit rst);
        bit rise[N];
        bit np[N];
        bit hs;
        bit any;
        int idx;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = b[i];
                m_pend[i] = 1'b0;
            end
            m_ptr = 0; m_id = 0; m_drops = 0; m_off = 1'b0;
            m_known = 1'b1;
            return;
        end
        hs = m_off && r;
        if (hs) exp_q.push_back(m_id);
        for (int i = 0; i < N; i++) begin
            rise[i] = b[i] && !m_prev[i];
            if (hs && i == m_id) begin
                np[i] = rise[i];
            end else begin
                if (rise[i] && m_pend[i]) m_drops++;
                np[i] = rise[i] || m_pend[i];
            end
        end
        if (m_drops > 255) m_drops = 255;
        if (!m_off) begin
            any = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!any && m_pend[idx]) begin
                    any = 1'b1;
                    m_id = idx;
                end
            end
            m_off = any;
        end else if (hs) begin
            m_ptr = (m_id + 1) % N;
            m_off = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            m_prev[i] = b[i];
            m_pend[i] = np[i];
        end
    endtask

    function automatic int model_pend_vec();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_pend[i]) v |= (1 << i);
        return v;
    endfunction

    // One cycle: check registered outputs against the model, then drive and advance the model.
    task automatic step(input logic [N-1:0] b, input bit r, input bit rst);
        @(posedge clk);
        #1;
        if (m_known) begin
            chk("event_valid", int'(event_valid), int'(m_off));
            chk("event_id_reg", int'(event_id), m_id);
            chk("pending", int'(pending), model_pend_vec());
            chk("drop_count", int'(drop_count), m_drops);
        end
        buttons     = b;
        event_ready = r;
        reset       = rst;
        model_step(b, r, rst);
    endtask

    always @(negedge clk) begin
        if (m_known && !reset && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                chk("event_id_unexpected", int'(event_id), -1);
            end else begin
                chk("event_id_accepted", int'(event_id), exp_q.pop_front());
            end
        end
    end

    task automatic wait_offer(input logic [N-1:0] b, input bit r);
        for (int k = 0; k < 8 && !event_valid; k++) step(b, r, 1'b0);
        chk("offer_within_bound", int'(event_valid), 1);
    endtask

    initial begin
        logic [N-1:0] rb;
        bit           rr;

        // Reset with button 1 held, then hold it for 10 cycles.
        for (int k = 0; k < 3; k++) step(4'b0010, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // Single press on bit 2, two-cycle latency.
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        chk("single_press_valid", int'(event_valid), 1);
        chk("single_press_id", int'(event_id), 2);
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 1'b0);

        // Simultaneous presses 0,1,3 then 0,1.
        step(4'b1011, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) step(4'b1011, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0011, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) step(4'b0000, 1'b1, 1'b0);

        // Backpressure: press button 1 three times.
        for (int k = 0; k < 3; k++) begin
            step(4'b0010, 1'b0, 1'b0);
            step(4'b0000, 1'b0, 1'b0);
            step(4'b0000, 1'b0, 1'b0);
        end
        chk("bp_held_id", int'(event_id), 1);
        chk("bp_drops", int'(drop_count), 2);
        for (int k = 0; k < 4; k++) step(4'b0000, 1'b1, 1'b0);
        chk("bp_pending_clear", int'(pending), 0);

        // Re-press of button 1 on its own handshake cycle.
        step(4'b0010, 1'b0, 1'b0);
        wait_offer(4'b0000, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("repress_pending_kept", int'(pending[1]), 1);
        chk("repress_no_drop", int'(drop_count), 2);
        for (int k = 0; k < 5; k++) step(4'b0000, 1'b1, 1'b0);

        // Drive 300+ drops on button 0 to saturate the counter.
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 300; k++) begin
            step(4'b0001, 1'b0, 1'b0);
            step(4'b0000, 1'b0, 1'b0);
        end
        step(4'b0000, 1'b0, 1'b0);
        chk("drop_saturated", int'(drop_count), 255);
        for (int k = 0; k < 4; k++) step(4'b0000, 1'b1, 1'b0);

        // Reset while id 3 is offered.
        step(4'b1000, 1'b0, 1'b0);
        wait_offer(4'b1000, 1'b0);
        chk("pre_reset_id", int'(event_id), 3);
        step(4'b1000, 1'b1, 1'b1);
        step(4'b1000, 1'b1, 1'b0);
        chk("post_reset_valid", int'(event_valid), 0);
        for (int k = 0; k < 6; k++) step(4'b1000, 1'b1, 1'b0);
        chk("post_reset_quiet", int'(event_valid), 0);

        // Randomized traffic with occasional reset.
        rb = '0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 2) == 0) rb = rb ^ 4'($urandom);
            rr = ($urandom_range(0, 2) != 0);
            step(rb, rr, ($urandom_range(0, 299) == 0));
        end
        for (int k = 0; k < 12; k++) step(4'b0000, 1'b1, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
